axi_vga_regs: RTL and testbench
===============================

# axi_vga_regs

Parametrised AXI4-Lite slave register bank for the VGA controller. It replaces the fixed four-register slave with:
- N configuration registers, double-buffered so that changes apply on frame boundaries;
- byte-strobe writes;
- a read-only status register;
- a write-one-to-clear interrupt block;
- SLVERR on unmapped addresses.

It sits between the PS/BD AXI interconnect and the VGA timing/pixel core.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6, byte-address width.
- NUM_CFG, 4, number of shadowed config registers; elaboration error if NUM_CFG+3 > 2^(C_S_AXI_ADDR_WIDTH-ADDR_LSB), where ADDR_LSB = clog2(C_S_AXI_DATA_WIDTH/8).
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  reset; synchronous and active-low.
- S_AXI_AWADDR/ARADDR  in  C_S_AXI_ADDR_WIDTH  byte addresses; bits below ADDR_LSB ignored.
- S_AXI_AWPROT/ARPROT  in  3  ignored.
- S_AXI_AWVALID/WVALID/ARVALID/BREADY/RREADY  in  1  AXI handshakes.
- S_AXI_AWREADY/WREADY/ARREADY/BVALID/RVALID  out  1  AXI handshakes.
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables.
- S_AXI_BRESP/RRESP  out  2  responses: OKAY=00, SLVERR=10.
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
- frame_start  in  1  one-cycle pulse from the timing core.
- vblank  in  1  level, high during vertical blanking.
- cfg_active  out  NUM_CFG*C_S_AXI_DATA_WIDTH  active config; register i occupies bits [i*DW +: DW].
- irq  out  1  level interrupt, registered.

## Operation
Register map (word index k = addr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]):
- k < NUM_CFG: CFG[k], RW. A write goes to shadow[k] and sets `pending`. Reads return shadow[k].
- k = NUM_CFG: STATUS, RO.
  - [15:0] frame_cnt
  - [16] vblank
  - [17] pending
  - Writes are ignored and return OKAY.
- k = NUM_CFG+1: IRQ_STAT, W1C.
  - Bit0 is set on frame_start.
  - Bit1 is set on the rising edge of vblank, detected against a registered copy of vblank.
- k = NUM_CFG+2: IRQ_EN, RW, bits [1:0]; other bits read 0.
- k > NUM_CFG+2: reads return 0 with SLVERR; writes are discarded and return SLVERR.

Write and update rules:
- WSTRB applies per byte to CFG and IRQ_EN. For IRQ_STAT, a bit clears only when its byte's strobe is set.
- On frame_start:
  - cfg_active ← shadow for all registers;
  - pending ← 0;
  - frame_cnt ← frame_cnt+1, modulo 2^16 (0xFFFF → 0x0000).
- irq register ← |(IRQ_STAT & IRQ_EN), updated every cycle.
- Reset: every output, shadow, cfg_active, frame_cnt, pending, IRQ_STAT, IRQ_EN and the vblank delay register are 0. BVALID=RVALID=AWREADY=WREADY=ARREADY=0.

## Timing
Write channel:
- AWREADY and WREADY are registered and rise together in the cycle after AWVALID&&WVALID are both seen while AWREADY=0 and BVALID=0. They are high for exactly one cycle.
- The register update and BVALID/BRESP both take effect at the edge closing the handshake cycle, so BVALID is visible 2 cycles after both valids.
- BVALID holds until BREADY. No new write is accepted while BVALID=1.
- AW-only or W-only is never accepted; the slave waits for both.

Read channel:
- ARREADY rises the cycle after ARVALID is seen with ARREADY=0 and RVALID=0, and is high for one cycle.
- RDATA/RRESP are latched at the handshake edge, so RVALID is visible 2 cycles after ARVALID.
- RDATA is stable and RVALID is held until RREADY.
- Read and write channels are independent and may complete in the same cycle.

Simultaneous events:
- CFG write and frame_start in the same cycle: cfg_active takes the old shadow, the shadow takes the new data, and pending stays 1.
- W1C and an interrupt set in the same cycle on the same bit: set wins.
- Reset asserted mid-transaction: all channel state returns to idle on the next edge, and the outstanding response is dropped.

## Structure
- Package axi_vga_regs_pkg contains:
  - RESP_OKAY / RESP_SLVERR constants;
  - IRQ bit indices (IRQ_FRAME=0, IRQ_VBLANK=1);
  - STATUS field positions;
  - localparam offsets relative to NUM_CFG, defined as functions of NUM_CFG.
- Sub-module axi_vga_irq_ctrl contains vblank edge detection, IRQ_STAT/IRQ_EN, W1C with strobe, and the irq output.
- The top level holds the AXI handshake FSMs (idle/resp per channel), shadow/active arrays, frame_cnt and pending.

## Test plan
- Reset, then read every mapped word → all 0, RRESP=00; check all outputs are 0 during reset.
- Write CFG[0]=0xA5A5_0001 → cfg_active[0] stays 0 and STATUS[17]=1; pulse frame_start → cfg_active[0]=0xA5A5_0001, STATUS[17]=0, frame_cnt=1.
- Write 0xFFFF_FFFF to CFG[1] with WSTRB=4'b0101 → read returns 0x00FF_00FF.
- Set IRQ_EN=3 and raise vblank → IRQ_STAT=2 and irq=1 one cycle after the IRQ_STAT set. W1C 0x2 → irq=0. W1C on the same cycle as a vblank rise → bit stays 1.
- Access word NUM_CFG+3 → BRESP=10 and RRESP=10 with RDATA=0. Then hold BREADY/RREADY low 5 cycles → BVALID/RVALID held, and a second AWVALID is not accepted.
- Force frame_cnt to 0xFFFF via 65535 frame_start pulses, then pulse again → frame_cnt=0. Also cover a CFG write coincident with frame_start → pending=1 and the new value applies on the next frame.

Source files
------------

// File: rtl/axi_vga_regs_pkg.sv
// rtl/axi_vga_regs_pkg.sv - shared constants and register map helpers for the VGA register bank
package axi_vga_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int IRQ_FRAME  = 0;
    localparam int IRQ_VBLANK = 1;
    localparam int IRQ_W      = 2;

    localparam int STATUS_FCNT_LSB    = 0;
    localparam int STATUS_FCNT_W      = 16;
    localparam int STATUS_VBLANK_BIT  = 16;
    localparam int STATUS_PENDING_BIT = 17;

    // Control words sit directly above the CFG block
    localparam int OFF_STATUS   = 0;
    localparam int OFF_IRQ_STAT = 1;
    localparam int OFF_IRQ_EN   = 2;
    localparam int NUM_EXTRA    = 3;

    function automatic int status_idx(input int num_cfg);
        return num_cfg + OFF_STATUS;
    endfunction

    function automatic int irq_stat_idx(input int num_cfg);
        return num_cfg + OFF_IRQ_STAT;
    endfunction

    function automatic int irq_en_idx(input int num_cfg);
        return num_cfg + OFF_IRQ_EN;
    endfunction

    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_RESP = 1'b1
    } ch_state_e;

endpackage

// File: rtl/axi_vga_irq_ctrl.sv
// rtl/axi_vga_irq_ctrl.sv - interrupt status/enable with write-one-to-clear and registered irq
module axi_vga_irq_ctrl
    import axi_vga_regs_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_start,
    input  logic             vblank,
    input  logic             stat_wr,
    input  logic             en_wr,
    input  logic             byte0_en,
    input  logic [IRQ_W-1:0] wbits,
    output logic [IRQ_W-1:0] irq_stat,
    output logic [IRQ_W-1:0] irq_en,
    output logic             irq
);

    logic             vblank_q;
    logic [IRQ_W-1:0] set_bits;
    logic [IRQ_W-1:0] clr_bits;

    always_comb begin
        set_bits             = '0;
        set_bits[IRQ_FRAME]  = frame_start;
        set_bits[IRQ_VBLANK] = vblank & ~vblank_q;
        clr_bits             = (stat_wr && byte0_en) ? wbits : '0;
    end

    // Set is applied after clear so a coincident event is never lost
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vblank_q <= 1'b0;
            irq_stat <= '0;
            irq_en   <= '0;
            irq      <= 1'b0;
        end else begin
            vblank_q <= vblank;
            irq_stat <= (irq_stat & ~clr_bits) | set_bits;
            if (en_wr && byte0_en) begin
                irq_en <= wbits;
            end
            irq <= |(irq_stat & irq_en);
        end
    end

endmodule

// File: rtl/axi_vga_regs.sv
// rtl/axi_vga_regs.sv - AXI4-Lite register bank with frame-synchronous config shadowing
module axi_vga_regs
    import axi_vga_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CFG            = 4
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
    input  logic [2:0]                            S_AXI_AWPROT,
    input  logic                                  S_AXI_AWVALID,
    output logic                                  S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
    input  logic                                  S_AXI_WVALID,
    output logic                                  S_AXI_WREADY,
    output logic [1:0]                            S_AXI_BRESP,
    output logic                                  S_AXI_BVALID,
    input  logic                                  S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
    input  logic [2:0]                            S_AXI_ARPROT,
    input  logic                                  S_AXI_ARVALID,
    output logic                                  S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
    output logic [1:0]                            S_AXI_RRESP,
    output logic                                  S_AXI_RVALID,
    input  logic                                  S_AXI_RREADY,
    input  logic                                  frame_start,
    input  logic                                  vblank,
    output logic [NUM_CFG*C_S_AXI_DATA_WIDTH-1:0] cfg_active,
    output logic                                  irq
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

    localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(status_idx(NUM_CFG));
    localparam logic [IDX_W-1:0] IDX_IRQ_STAT = IDX_W'(irq_stat_idx(NUM_CFG));
    localparam logic [IDX_W-1:0] IDX_IRQ_EN   = IDX_W'(irq_en_idx(NUM_CFG));

    generate
        if (NUM_CFG + NUM_EXTRA > 2 ** IDX_W) begin : g_map_too_small
            $error("axi_vga_regs: NUM_CFG+3 words do not fit the address space");
        end
        if (DW != 32 && DW != 64) begin : g_bad_width
            $error("axi_vga_regs: data width must be 32 or 64");
        end
    endgenerate

    ch_state_e wr_state;
    ch_state_e rd_state;

    logic [DW-1:0]            shadow [NUM_CFG];
    logic [STATUS_FCNT_W-1:0] frame_cnt;
    logic                     pending;
    logic [IRQ_W-1:0]         irq_stat;
    logic [IRQ_W-1:0]         irq_en;

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_fire;
    logic             rd_fire;
    logic             wr_cfg;
    logic             wr_mapped;
    logic             rd_err;
    logic [DW-1:0]    rd_word;
    logic [DW-1:0]    status_word;
    logic             unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign wr_idx    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign wr_fire   = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire   = S_AXI_ARREADY && S_AXI_ARVALID;
    assign wr_cfg    = wr_fire && (wr_idx < IDX_STATUS);
    assign wr_mapped = !(wr_idx > IDX_IRQ_EN);
    assign rd_err    = rd_idx > IDX_IRQ_EN;

    always_comb begin
        status_word = '0;
        status_word[STATUS_FCNT_LSB +: STATUS_FCNT_W] = frame_cnt;
        status_word[STATUS_VBLANK_BIT]                = vblank;
        status_word[STATUS_PENDING_BIT]               = pending;
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_word = shadow[i];
            end
        end
        if (rd_idx == IDX_STATUS)   rd_word = status_word;
        if (rd_idx == IDX_IRQ_STAT) rd_word = DW'(irq_stat);
        if (rd_idx == IDX_IRQ_EN)   rd_word = DW'(irq_en);
    end

    // READY pulses for one cycle; the handshake edge commits the write and raises BVALID
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state      <= CH_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
        end else begin
            case (wr_state)
                CH_IDLE: begin
                    if (S_AXI_AWREADY) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        if (S_AXI_AWVALID && S_AXI_WVALID) begin
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                            wr_state     <= CH_RESP;
                        end
                    end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                CH_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        wr_state     <= CH_IDLE;
                    end
                end
                default: wr_state <= CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rd_state      <= CH_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RDATA   <= '0;
        end else begin
            case (rd_state)
                CH_IDLE: begin
                    if (S_AXI_ARREADY) begin
                        S_AXI_ARREADY <= 1'b0;
                        if (S_AXI_ARVALID) begin
                            S_AXI_RVALID <= 1'b1;
                            S_AXI_RDATA  <= rd_word;
                            S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                            rd_state     <= CH_RESP;
                        end
                    end else if (S_AXI_ARVALID) begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                CH_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        rd_state     <= CH_IDLE;
                    end
                end
                default: rd_state <= CH_IDLE;
            endcase
        end
    end

    // A CFG write racing frame_start lands in the shadow and keeps pending set for the next frame
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                shadow[i] <= '0;
            end
            cfg_active <= '0;
            frame_cnt  <= '0;
            pending    <= 1'b0;
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_CFG; i++) begin
                    cfg_active[i*DW +: DW] <= shadow[i];
                end
                frame_cnt <= frame_cnt + 1'b1;
            end
            for (int i = 0; i < NUM_CFG; i++) begin
                if (wr_cfg && wr_idx == IDX_W'(i)) begin
                    for (int b = 0; b < SW; b++) begin
                        if (S_AXI_WSTRB[b]) begin
                            shadow[i][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                        end
                    end
                end
            end
            if (wr_cfg) begin
                pending <= 1'b1;
            end else if (frame_start) begin
                pending <= 1'b0;
            end
        end
    end

    axi_vga_irq_ctrl u_irq_ctrl (
        .clk         (ACLK),
        .resetn      (ARESETN),
        .frame_start (frame_start),
        .vblank      (vblank),
        .stat_wr     (wr_fire && wr_idx == IDX_IRQ_STAT),
        .en_wr       (wr_fire && wr_idx == IDX_IRQ_EN),
        .byte0_en    (S_AXI_WSTRB[0]),
        .wbits       (S_AXI_WDATA[IRQ_W-1:0]),
        .irq_stat    (irq_stat),
        .irq_en      (irq_en),
        .irq         (irq)
    );

endmodule

// File: tb/tb_axi_vga_regs.sv
// tb/tb_axi_vga_regs.sv - self-checking bench for axi_vga_regs
module tb_axi_vga_regs;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [5:0]   S_AXI_AWADDR = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b0;
    logic [5:0]   S_AXI_ARADDR = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b0;
    logic         frame_start = 1'b0;
    logic         vblank = 1'b0;
    logic [127:0] cfg_active;
    logic         irq;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_shadow [4];
    logic [31:0] m_active [4];
    logic [15:0] m_fcnt;
    logic        m_pend;
    logic [1:0]  m_stat;
    logic [1:0]  m_en;
    logic        m_irq;
    logic        m_vbq;

    axi_vga_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (6),
        .NUM_CFG            (4)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .frame_start   (frame_start),
        .vblank        (vblank),
        .cfg_active    (cfg_active),
        .irq           (irq)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Register-map level model, advanced on each rising edge from the bus and timing inputs
    always @(posedge ACLK) begin : model
        bit fire;
        int k;
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            m_fcnt = '0; m_pend = 0; m_stat = '0; m_en = '0; m_irq = 0; m_vbq = 0;
        end else begin
            fire = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
            k = int'(S_AXI_AWADDR) / 4;
            m_irq = (m_stat & m_en) != 2'b00;
            if (fire && k == 5 && S_AXI_WSTRB[0]) m_stat = m_stat & ~S_AXI_WDATA[1:0];
            if (frame_start) m_stat[0] = 1'b1;
            if (vblank && !m_vbq) m_stat[1] = 1'b1;
            m_vbq = vblank;
            if (fire && k == 6 && S_AXI_WSTRB[0]) m_en = S_AXI_WDATA[1:0];
            if (frame_start) begin
                for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
                m_pend = 0;
                m_fcnt = m_fcnt + 16'd1;
            end
            if (fire && k < 4) begin
                for (int b = 0; b < 4; b++)
                    if (S_AXI_WSTRB[b]) m_shadow[k][b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
                m_pend = 1;
            end
        end
    end

    always @(negedge ACLK) begin
        if (chk_en) begin
            total++;
            if (cfg_active !== {m_active[3], m_active[2], m_active[1], m_active[0]}) begin
                bad++;
                $display("FAIL cfg_active: got %h expected %h", cfg_active,
                         {m_active[3], m_active[2], m_active[1], m_active[0]});
            end
            total++;
            if (irq !== m_irq) begin
                bad++;
                $display("FAIL irq: got %b expected %b", irq, m_irq);
            end
        end
    end

    function automatic logic [31:0] exp_word(input int k);
        if (k < 4) return m_shadow[k];
        if (k == 4) return {14'd0, m_pend, vblank, m_fcnt};
        if (k == 5) return {30'd0, m_stat};
        if (k == 6) return {30'd0, m_en};
        return 32'd0;
    endfunction

    task automatic rd(input int k, output logic [31:0] d);
        int lat;
        @(negedge ACLK);
        S_AXI_ARADDR = 6'(k * 4); S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
        lat = 0;
        do begin
            @(negedge ACLK);
            lat++;
            if (lat == 1) check("arready_rise", S_AXI_ARREADY, 1);
        end while (!S_AXI_RVALID && lat < 20);
        S_AXI_ARVALID = 0;
        check("rd_latency", lat, 2);
        check("rresp", S_AXI_RRESP, (k > 6) ? 2 : 0);
        check("rdata", S_AXI_RDATA, exp_word(k));
        d = S_AXI_RDATA;
    endtask

    // evt: 1 = frame_start, 2 = vblank rise, both timed onto the handshake cycle
    task automatic wr(input int k, input logic [31:0] d, input logic [3:0] s, input int evt);
        int lat;
        @(negedge ACLK);
        S_AXI_AWADDR = 6'(k * 4); S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        lat = 0;
        do begin
            @(negedge ACLK);
            lat++;
            if (lat == 1) begin
                check("awready_wready_rise", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
                if (evt == 1) frame_start = 1;
                if (evt == 2) vblank = 1;
            end
        end while (!S_AXI_BVALID && lat < 20);
        frame_start = 0;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        check("wr_latency", lat, 2);
        check("bresp", S_AXI_BRESP, (k > 6) ? 2 : 0);
    endtask

    task automatic frame_pulse();
        @(negedge ACLK); frame_start = 1;
        @(negedge ACLK); frame_start = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int n;
        repeat (2) @(negedge ACLK);
        check("reset_handshakes", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}, 0);
        check("reset_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 0);
        check("reset_cfg_irq", {|cfg_active, irq}, 0);
        chk_en = 1;
        @(negedge ACLK); ARESETN = 1;

        for (int k = 0; k < 7; k++) begin
            rd(k, d);
            check("reset_word", d, 0);
        end

        wr(0, 32'hA5A5_0001, 4'hF, 0);
        check("cfg0_not_yet_active", cfg_active[31:0], 0);
        rd(4, d);
        check("status_pending_set", d[17], 1);
        frame_pulse();
        check("cfg0_active", cfg_active[31:0], 32'hA5A5_0001);
        rd(4, d);
        check("status_after_frame", d, 32'h0000_0001);

        wr(1, 32'hFFFF_FFFF, 4'b0101, 0);
        rd(1, d);
        check("cfg1_strobe", d, 32'h00FF_00FF);

        wr(2, 32'h1234_5678, 4'hF, 1);
        check("cfg2_old_on_race", cfg_active[95:64], 0);
        rd(4, d);
        check("status_race", d, 32'h0002_0002);
        frame_pulse();
        check("cfg2_next_frame", cfg_active[95:64], 32'h1234_5678);
        rd(4, d);
        check("status_after_race_frame", d, 32'h0000_0003);

        wr(5, 32'h3, 4'hF, 0);
        wr(6, 32'h3, 4'hF, 0);
        rd(6, d);
        check("irq_en_read", d, 32'h3);
        @(negedge ACLK); vblank = 1;
        @(negedge ACLK);
        check("irq_lag", irq, 0);
        @(negedge ACLK);
        check("irq_vblank", irq, 1);
        rd(5, d);
        check("irq_stat_vblank", d, 32'h2);
        wr(5, 32'h2, 4'hF, 0);
        @(negedge ACLK);
        check("irq_cleared", irq, 0);
        rd(5, d);
        check("irq_stat_cleared", d, 32'h0);

        @(negedge ACLK); vblank = 0;
        @(negedge ACLK);
        wr(5, 32'h2, 4'hF, 2);
        rd(5, d);
        check("w1c_set_wins", d, 32'h2);
        wr(5, 32'h2, 4'b1110, 0);
        rd(5, d);
        check("w1c_no_strobe", d, 32'h2);
        wr(5, 32'h2, 4'b0001, 0);
        rd(5, d);
        check("w1c_strobe", d, 32'h0);

        wr(7, 32'hDEAD_BEEF, 4'hF, 0);
        rd(7, d);
        check("unmapped_rdata", d, 0);

        @(negedge ACLK);
        S_AXI_AWADDR = 6'd28; S_AXI_WDATA = 32'h5555_5555; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
        S_AXI_ARADDR = 6'd28; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
        repeat (2) @(negedge ACLK);
        check("hold_valids_up", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        S_AXI_ARVALID = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("hold_b", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_BRESP}, 4'b1010);
            check("hold_r", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, 2'b10, 32'd0});
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1; S_AXI_RREADY = 1;
        @(negedge ACLK);
        check("hold_release", {S_AXI_BVALID, S_AXI_RVALID}, 0);

        n = 32'hFFFF - int'(m_fcnt);
        @(negedge ACLK); frame_start = 1;
        repeat (n) @(negedge ACLK);
        frame_start = 0;
        rd(4, d);
        check("frame_cnt_max", d[15:0], 16'hFFFF);
        frame_pulse();
        rd(4, d);
        check("frame_cnt_wrap", d[15:0], 16'h0000);

        @(negedge ACLK);
        S_AXI_AWADDR = 6'd0; S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
        @(negedge ACLK);
        ARESETN = 0;
        @(negedge ACLK);
        check("reset_mid_txn", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 0);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
        ARESETN = 1;
        rd(0, d);
        check("reset_drops_write", d, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
